mix_columns_seq: RTL

- Iterative AES MixColumns / InvMixColumns engine with valid/ready handshakes on both sides.
- Processes COLS_PER_CYCLE of the 4 state columns per clock, so area and throughput trade against each other.
- Sits in the round datapath between ShiftRows and AddRoundKey. Replaces the purely combinational column mixer where the round logic is iterative.

---
 rtl/mix_columns_seq.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mix_columns_seq.sv
`default_nettype none
// ============================================================================
//  Module   : mix_columns_seq
//  Purpose  : Iterative AES MixColumns / InvMixColumns engine. A 128-bit
//             state is latched on an input handshake, COLS_PER_CYCLE columns
//             are mixed per clock, and the result is presented on an output
//             handshake until the downstream consumer takes it.
//  Optional : MIX_COLUMNS_SEQ_INV_EN
//             - defined  : inverse datapath built, inv selects the mode
//             - undefined: forward mode only, inv is ignored
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk        in   1    rising-edge clock
//    rst        in   1    asynchronous, active-high reset
//    in_valid   in   1    state_in / inv valid
//    in_ready   out  1    engine idle, able to take a state
//    inv        in   1    0 = MixColumns, 1 = InvMixColumns (sampled on accept)
//    state_in   in   128  column c = [32c+31:32c], row 0 in the top byte
//    out_valid  out  1    state_out holds a finished result
//    out_ready  in   1    downstream accepts state_out
//    state_out  out  128  mixed state, same packing as state_in
//    busy       out  1    engine is mixing or holding a result
// ============================================================================
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         inv,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
  output logic         busy
);

  // --------------------------------------------------------------------------
  // Parameter legality
  // --------------------------------------------------------------------------
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
      $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  localparam int STEPS = 4 / COLS_PER_CYCLE;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(STEPS - 1);

  // --------------------------------------------------------------------------
  // GF(2^8) helpers
  // --------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward column: b_i = 2.a_i ^ 3.a_(i+1) ^ a_(i+2) ^ a_(i+3)
  function automatic logic [31:0] mix_col_fwd(input logic [31:0] col);
    logic [7:0] a [4];
    logic [7:0] b [4];
    a[0] = col[31:24];
    a[1] = col[23:16];
    a[2] = col[15:8];
    a[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      b[i] = xtime(a[i]) ^ xtime(a[(i + 1) % 4]) ^ a[(i + 1) % 4]
           ^ a[(i + 2) % 4] ^ a[(i + 3) % 4];
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction

`ifdef MIX_COLUMNS_SEQ_INV_EN
  // Inverse column: b_i = e.a_i ^ b.a_(i+1) ^ d.a_(i+2) ^ 9.a_(i+3)
  // The x2/x4/x8 multiples of each byte are shared by all four outputs.
  function automatic logic [31:0] mix_col_inv(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] b  [4];
    a[0] = col[31:24];
    a[1] = col[23:16];
    a[2] = col[15:8];
    a[3] = col[7:0];
    for (int i = 0; i < 4; i++) begin
      m2[i] = xtime(a[i]);
      m4[i] = xtime(m2[i]);
      m8[i] = xtime(m4[i]);
    end
    for (int i = 0; i < 4; i++) begin
      b[i] = (m8[i] ^ m4[i] ^ m2[i])                                 // 0e
           ^ (m8[(i + 1) % 4] ^ m2[(i + 1) % 4] ^ a[(i + 1) % 4])    // 0b
           ^ (m8[(i + 2) % 4] ^ m4[(i + 2) % 4] ^ a[(i + 2) % 4])    // 0d
           ^ (m8[(i + 3) % 4] ^ a[(i + 3) % 4]);                     // 09
    end
    return {b[0], b[1], b[2], b[3]};
  endfunction
`endif

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [127:0]    work_q,  work_d;
  logic [CW-1:0]   cnt_q,   cnt_d;

`ifdef MIX_COLUMNS_SEQ_INV_EN
  logic            inv_q,   inv_d;
`else
  logic            unused_inv;
  assign unused_inv = inv;
`endif

  // --------------------------------------------------------------------------
  // Column mixers, one per lane. Lane l of step k works on column k*C+l.
  // --------------------------------------------------------------------------
  logic [1:0]  col_idx   [COLS_PER_CYCLE];
  logic [31:0] col_in    [COLS_PER_CYCLE];
  logic [31:0] mixed_col [COLS_PER_CYCLE];

  generate
    for (genvar l = 0; l < COLS_PER_CYCLE; l++) begin : g_mixer
      assign col_idx[l] = 2'(int'(cnt_q) * COLS_PER_CYCLE + l);
      assign col_in[l]  = work_q[{col_idx[l], 5'b00000} +: 32];
`ifdef MIX_COLUMNS_SEQ_INV_EN
      assign mixed_col[l] = inv_q ? mix_col_inv(col_in[l]) : mix_col_fwd(col_in[l]);
`else
      assign mixed_col[l] = mix_col_fwd(col_in[l]);
`endif
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
`ifdef MIX_COLUMNS_SEQ_INV_EN
    inv_d   = inv_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          work_d  = state_in;
          cnt_d   = '0;
`ifdef MIX_COLUMNS_SEQ_INV_EN
          inv_d   = inv;
`endif
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        for (int l = 0; l < COLS_PER_CYCLE; l++) begin
          work_d[{col_idx[l], 5'b00000} +: 32] = mixed_col[l];
        end
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        // Leaving DONE never accepts in the same cycle; in_ready is low here.
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
`ifdef MIX_COLUMNS_SEQ_INV_EN
      inv_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
`ifdef MIX_COLUMNS_SEQ_INV_EN
      inv_q   <= inv_d;
`endif
    end
  end

  // --------------------------------------------------------------------------
  // Outputs, decoded from the registered state
  // --------------------------------------------------------------------------
  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign state_out = work_q;

endmodule
`default_nettype wire
